// File: rtl/fifo_pkg.sv
// fifo_pkg: shared arbiter state encoding and default data width for the FIFO write/read interfaces
package fifo_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: round-robin search for the first non-excluded request at or after start, wrapping to 0
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] start,
  input  logic [NUM_REQ-1:0]         excl,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       found
);
  localparam int W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] cand;
  assign cand = req & ~excl;
  // scan from the far end back toward start so the nearest candidate is written last and wins
  always_comb begin
    logic [W-1:0] j;
    j = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = W'((int'(start) + k) % NUM_REQ);
      if (cand[j]) begin
        idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter granting one requester at a time the FIFO write port
module fifo_write_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          write_en,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int W  = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t state;
  logic [W-1:0] owner, rr_ptr, nxt_ptr, pick_start, pick_idx;
  logic [CW-1:0] burst_cnt;
  logic [NUM_REQ-1:0] own_mask, pick_excl;
  logic hs, rel, found;
  assign busy       = state == BURST;
  assign own_mask   = NUM_REQ'(1) << owner;
  assign hs         = busy && req_valid[owner] && !full;
  assign rel        = busy && (!req_valid[owner] || (hs && burst_cnt == CW'(MAX_BURST - 1)));
  assign nxt_ptr    = owner == W'(NUM_REQ - 1) ? '0 : owner + 1'b1;
  assign pick_start = busy ? nxt_ptr : rr_ptr;
  assign pick_excl  = busy && |(req_valid & ~own_mask) ? own_mask : '0;
  assign write_en   = hs;
  assign req_ready  = busy && !full ? own_mask : '0;
  assign write_data = busy ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_id   = owner;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req_valid),
    .start (pick_start),
    .excl  (pick_excl),
    .idx   (pick_idx),
    .found (found)
  );
  // grant from idle, hand over on release without a bubble, count only accepted words
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else if (!busy) begin
      if (found) begin
        state     <= BURST;
        owner     <= pick_idx;
        burst_cnt <= '0;
      end
    end else if (rel) begin
      rr_ptr    <= nxt_ptr;
      burst_cnt <= '0;
      if (found) owner <= pick_idx;
      else state <= IDLE;
    end else if (hs) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: randomized scoreboard bench against a behavioural round-robin burst model
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int W  = 2;
  logic clk = 1'b0, rstn = 1'b0, full = 1'b0, write_en, busy;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic [DW-1:0] write_data;
  logic [W-1:0] grant_id;
  typedef struct {
    logic busy;
    int gid;
    logic [N-1:0] ready;
    logic [DW-1:0] wdata;
  } cyc_t;
  typedef struct {
    int id;
    logic [DW-1:0] data;
  } wr_t;
  cyc_t cyc_q[$];
  wr_t wr_q[$];
  cyc_t mc;
  wr_t mw;
  int checks = 0, failures = 0;
  int m_owner = -1, m_gid = 0, m_ptr = 0, m_used = 0;
  int wait_cnt[N];
  int writes = 0, hs_sum = 0;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .write_en   (write_en),
    .write_data (write_data),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic bit has(logic [N-1:0] v, int i);
    return (int'(v >> i) & 1) != 0;
  endfunction

  // nearest valid requester from start; the releasing requester only if nobody else wants the port
  function automatic int pick(int start, logic [N-1:0] v, int excl);
    for (int k = 0; k < N; k++) begin
      int i = (start + k) % N;
      if (has(v, i) && i != excl) return i;
    end
    return (excl >= 0 && has(v, excl)) ? excl : -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle, record what the port should show, then advance the model to the next edge
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic f);
    cyc_t c;
    wr_t w;
    int o;
    @(posedge clk);
    #1;
    rstn = r;
    req_valid = v;
    full = f;
    req_data = (N*DW)'($urandom);
    o = m_owner;
    c.busy = o >= 0;
    c.gid = m_gid;
    c.ready = (o >= 0 && !f) ? N'(1) << o : '0;
    c.wdata = o >= 0 ? DW'(req_data >> (o * DW)) : '0;
    cyc_q.push_back(c);
    if (o >= 0 && has(v, o) && !f) begin
      w.id = o;
      w.data = c.wdata;
      wr_q.push_back(w);
      m_used++;
    end
    if (!r) begin
      m_owner = -1;
      m_gid = 0;
      m_ptr = 0;
      m_used = 0;
    end else if (o < 0) begin
      m_owner = pick(m_ptr, v, -1);
      m_used = 0;
    end else if (!has(v, o) || m_used == MB) begin
      m_ptr = (o + 1) % N;
      m_owner = pick(m_ptr, v, o);
      m_used = 0;
    end
    if (m_owner >= 0) m_gid = m_owner;
  endtask

  // monitor: compare the port state every cycle and pop an expected word whenever a write appears
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mc = cyc_q.pop_front();
      chk("busy", int'(busy), int'(mc.busy));
      chk("grant_id", int'(grant_id), mc.gid);
      chk("req_ready", int'(req_ready), int'(mc.ready));
      chk("write_data", int'(write_data), int'(mc.wdata));
      chk("write_while_full", int'(write_en && full), 0);
      if (write_en) begin
        writes++;
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mw = wr_q.pop_front();
          chk("write_owner", int'(grant_id), mw.id);
          chk("write_word", int'(write_data), int'(mw.data));
        end
      end
      if (wr_q.size() != 0) begin
        chk("missed_write", wr_q.size(), 0);
        wr_q.delete();
      end
      hs_sum += $countones(req_valid & req_ready);
      for (int i = 0; i < N; i++) begin
        if (!rstn || !has(req_valid, i) || (busy && int'(grant_id) == i)) wait_cnt[i] = 0;
        else if (write_en) begin
          wait_cnt[i]++;
          chk("starvation", int'(wait_cnt[i] <= (N - 1) * MB), 1);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] nv;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    repeat (2) cycle(1'b0, '0, 1'b0);
    repeat (10) cycle(1'b1, 4'b0001, 1'b0);
    repeat (24) cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b0, '0, 1'b0);
    repeat (3) cycle(1'b1, 4'b0100, 1'b0);
    repeat (5) cycle(1'b1, 4'b0100, 1'b1);
    repeat (4) cycle(1'b1, 4'b0100, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b1010, 1'b0);
    repeat (4) cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b0, '0, 1'b0);
    repeat (3) cycle(1'b1, 4'b1000, 1'b0);
    cycle(1'b0, 4'b1010, 1'b0);
    repeat (4) cycle(1'b1, 4'b1010, 1'b0);
    repeat (10000) begin
      nv = req_valid;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) nv ^= N'(1) << i;
      cycle($urandom_range(0, 999) != 0, nv, $urandom_range(0, 3) == 0);
    end
    repeat (2) cycle(1'b1, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("write_count", writes, hs_sum);
    chk("pending_cycles", cyc_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
